// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
package piso_tx_pkg;

  `include "piso_tx_defs.vh"

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

  // Bit-counter width; a one-bit frame still needs a one-bit counter.
  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Parallel-load / serial-out bus between a frame source and piso_tx.
interface piso_tx_if #(
  parameter int WIDTH = 4
) ();

  logic             ce;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             sdo;
  logic             busy;
  logic             done;

  modport master (
    output ce, load, d,
    input  sdo, busy, done
  );

  modport slave (
    input  ce, load, d,
    output sdo, busy, done
  );

endinterface

// File: rtl/piso_tx_bit_cnt.sv
// Data-bit counter for piso_tx: synchronous clear at frame start, counts enabled bits.
module bit_cnt
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          clr_sync,
  input  logic                          en,
  output logic [cntWidth(WIDTH)-1:0]    cnt
);

  localparam int CW = cntWidth(WIDTH);

  // Counter register: async clear, sync clear has priority over counting.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (clr_sync) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_tx_defs.vh
// State encodings for the piso_tx frame FSM, shared by the RTL and the bench.
`ifndef PISO_TX_DEFS_VH
`define PISO_TX_DEFS_VH
localparam logic [2:0] ST_IDLE   = 3'd0;
localparam logic [2:0] ST_START  = 3'd1;
localparam logic [2:0] ST_DATA   = 3'd2;
localparam logic [2:0] ST_PARITY = 3'd3;
localparam logic [2:0] ST_STOP   = 3'd4;
`endif

// File: rtl/piso_tx.sv
// Serial frame transmitter: start(0), WIDTH data bits LSB first, even parity, stop(1).
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      clr_n,
  piso_tx_if.slave  bus
);

  localparam int CW = cntWidth(WIDTH);

  state_e           r_state;
  state_e           w_nextState;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_nextShift;
  logic             r_parity;
  logic             w_nextParity;
  logic             r_sdo;
  logic             w_nextSdo;
  logic             r_busy;
  logic             w_nextBusy;
  logic             r_done;
  logic             w_nextDone;
  logic             w_cntClr;
  logic             w_cntEn;
  logic             w_lastBit;
  logic [CW-1:0]    w_cnt;

  bit_cnt #(
    .WIDTH    (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .clr_n    (clr_n),
    .clr_sync (w_cntClr),
    .en       (w_cntEn),
    .cnt      (w_cnt)
  );

  assign w_lastBit = (w_cnt == CW'(WIDTH - 1));

  assign bus.sdo  = r_sdo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // FSM state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state, datapath updates and the output values for the next cycle.
  always_comb begin
    w_nextState  = r_state;
    w_nextShift  = r_shift;
    w_nextParity = r_parity;
    w_nextDone   = 1'b0;
    w_cntClr     = 1'b0;
    w_cntEn      = 1'b0;
    w_nextSdo    = 1'b1;
    w_nextBusy   = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_nextState  = START;
          w_nextShift  = bus.d;
          w_nextParity = ^bus.d;
          w_cntClr     = 1'b1;
        end
      end
      START: begin
        if (bus.ce) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (bus.ce) begin
          w_nextShift = r_shift >> 1;
          w_cntEn     = !w_lastBit;
          if (w_lastBit) begin
            w_nextState = PARITY;
          end
        end
      end
      PARITY: begin
        if (bus.ce) begin
          w_nextState = STOP;
        end
      end
      STOP: begin
        if (bus.ce) begin
          w_nextState = IDLE;
          w_nextDone  = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    w_nextBusy = (w_nextState != IDLE);

    case (w_nextState)
      START:   w_nextSdo = 1'b0;
      DATA:    w_nextSdo = w_nextShift[0];
      PARITY:  w_nextSdo = w_nextParity;
      default: w_nextSdo = 1'b1;
    endcase
  end

  // Shift register, parity and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_sdo    <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_shift  <= w_nextShift;
      r_parity <= w_nextParity;
      r_sdo    <= w_nextSdo;
      r_busy   <= w_nextBusy;
      r_done   <= w_nextDone;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: expected frame bits are queued at load time and
// popped whenever the transmitter starts a new bit.
module tb_piso_tx;
  import piso_tx_pkg::*;

  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = WIDTH + 3;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;

  piso_tx_if #(.WIDTH(WIDTH)) bus ();

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int   checksTotal  = 0;
  int   checksPassed = 0;
  logic expQ[$];
  logic expCur       = 1'b1;
  logic lastBusy     = 1'b0;
  int   bitIdx       = 0;
  int   framesDone   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
  endtask

  // Reference frame: start 0, data LSB first, even parity, stop 1.
  function automatic void pushFrame(input logic [WIDTH-1:0] data);
    expQ.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) expQ.push_back(data[i]);
    expQ.push_back(^data);
    expQ.push_back(1'b1);
  endfunction

  // Monitor: a new bit begins when busy rises or when busy stays up across a ce edge.
  always @(posedge clk) begin : monitor
    logic edgeCe;
    logic doneExp;
    #1;
    edgeCe = bus.ce;
    if (clr_n) begin
      if (bus.busy && (!lastBusy || edgeCe)) begin
        if (!lastBusy) bitIdx = 0;
        checkOutput("bit_expected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          expCur = expQ.pop_front();
          checkOutput("sdo_bit", 32'(bus.sdo), 32'(expCur));
        end
        bitIdx++;
      end
      if (!bus.busy) checkOutput("sdo_idle", 32'(bus.sdo), 32'd1);
      doneExp = lastBusy && edgeCe && !bus.busy && (bitIdx == FRAME_LEN);
      checkOutput("done", 32'(bus.done), 32'(doneExp));
      if (bus.done) framesDone++;
    end
    lastBusy = bus.busy;
  end

  // One frame with ce high on every period-th clk; optionally a stray load/d=all-ones mid-DATA.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input int period, input logic intrude);
    int busyCnt = 0;
    int doneCnt = 0;
    bit idle    = 1'b0;
    pushFrame(data);
    bus.d    = data;
    bus.load = 1'b1;
    bus.ce   = 1'b1;
    for (int k = 1; k <= period * FRAME_LEN + 4 && !idle; k++) begin
      @(negedge clk);
      if (bus.busy) begin
        busyCnt++;
        checkOutput("sdo_hold", 32'(bus.sdo), 32'(expCur));
        bus.load = intrude && (k == 2 || k == 3);
        bus.d    = intrude ? '1 : ~data;
        bus.ce   = (k % period) == 0;
      end else begin
        idle = 1'b1;
        if (bus.done) doneCnt++;
      end
    end
    bus.load = 1'b0;
    checkOutput("busy_cycles", 32'(busyCnt), 32'(period * FRAME_LEN));
    checkOutput("done_pulses", 32'(doneCnt), 32'd1);
    checkOutput("frame_drained", 32'(expQ.size()), 32'd0);
  endtask

  // Start a frame and pull reset low while the parity bit is on the line.
  task automatic abortFrame(input logic [WIDTH-1:0] data);
    pushFrame(data);
    bus.d    = data;
    bus.load = 1'b1;
    bus.ce   = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (WIDTH + 1) @(negedge clk);
    checkOutput("abort_pre_busy", 32'(bus.busy), 32'd1);
    checkOutput("abort_pre_sdo", 32'(bus.sdo), 32'(^data));
    #3 clr_n = 1'b0;
    #1;
    checkOutput("abort_sdo", 32'(bus.sdo), 32'd1);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    expQ.delete();
    bitIdx = 0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  // load held high: frames must follow each other with exactly one idle cycle between.
  task automatic backToBack();
    logic [WIDTH-1:0] frameData [3];
    int idleCnt      = 0;
    int framesBefore = framesDone;
    frameData[0] = WIDTH'(4'b1001);
    frameData[1] = WIDTH'(4'b0110);
    frameData[2] = WIDTH'(4'b1101);
    for (int f = 0; f < 3; f++) pushFrame(frameData[f]);
    bus.ce   = 1'b1;
    bus.load = 1'b1;
    bus.d    = frameData[0];
    for (int k = 1; k <= 3 * (FRAME_LEN + 1); k++) begin
      @(negedge clk);
      if (!bus.busy) idleCnt++;
      if ((k % (FRAME_LEN + 1)) == 0 && (k / (FRAME_LEN + 1)) < 3)
        bus.d = frameData[k / (FRAME_LEN + 1)];
      else
        bus.d = WIDTH'($urandom);
      if (k == 2 * (FRAME_LEN + 1) + 1) bus.load = 1'b0;
    end
    checkOutput("b2b_idle_cycles", 32'(idleCnt), 32'd3);
    checkOutput("b2b_frames", 32'(framesDone - framesBefore), 32'd3);
    checkOutput("b2b_drained", 32'(expQ.size()), 32'd0);
  endtask

  // Test sequence.
  initial begin
    bus.ce   = 1'b0;
    bus.load = 1'b0;
    bus.d    = '0;
    #5 clr_n = 1'b0;
    #1;
    checkOutput("reset_sdo", 32'(bus.sdo), 32'd1);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_state", 32'(dut.r_state), 32'(ST_IDLE));
    checkOutput("reset_shift", 32'(dut.r_shift), 32'd0);
    checkOutput("reset_cnt", 32'(dut.w_cnt), 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    applyStimulus(WIDTH'(4'b1010), 1, 1'b0);
    applyStimulus(WIDTH'(4'b0111), 4, 1'b0);
    applyStimulus(WIDTH'(4'b0001), 1, 1'b1);
    abortFrame(WIDTH'(4'b0011));
    applyStimulus(WIDTH'(4'b0101), 1, 1'b0);
    backToBack();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(WIDTH'($urandom), int'($urandom_range(3, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("final_idle", 32'(bus.busy), 32'd0);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, default 4, number of data bits per frame.
REQ-002 Port: clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 Port: clr_n  input  1  asynchronous, active-low reset.
REQ-004 Port: ce  input  1  bit-rate clock enable; the frame advances only on clk edges with ce=1.
REQ-005 Port: load  input  1  start-of-frame request; honoured only in IDLE.
REQ-006 Port: d  input  WIDTH  parallel data word, captured on load acceptance.
REQ-007 Port: sdo  output  1  serial data out; idles high.
REQ-008 Port: busy  output  1  high from load acceptance until return to IDLE.
REQ-009 Port: done  output  1  one-clk pulse on the edge that completes STOP.

Function
REQ-010 Frame SHALL be: start bit (0), WIDTH data bits LSB first, even-parity bit (XOR of captured d), stop bit (1).
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, and outputs SHALL be registered.
REQ-012 IDLE: an edge with load=1 SHALL capture d into the shift register, clear the bit counter, and enter START, independent of ce.
REQ-013 START->DATA, DATA->PARITY (after bit WIDTH-1), PARITY->STOP and STOP->IDLE SHALL occur only on edges with ce=1; with ce=0 the state and sdo SHALL hold.
REQ-014 DATA SHALL shift the register right by one and increment the counter on each ce edge; the counter SHALL be clog2(WIDTH) bits wide and SHALL NOT wrap within a frame.
REQ-015 sdo SHALL equal 0 in START, shift-register bit 0 in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 done SHALL be 1 for exactly the single clk cycle after the STOP->IDLE edge, and 0 at all other times.
REQ-018 load while busy=1 SHALL be ignored; d changes after capture SHALL NOT affect the frame in flight.
REQ-019 load=1 on the STOP->IDLE edge SHALL be ignored; a new load SHALL be accepted no earlier than the following edge.
REQ-020 With ce held at 1, the interval from the load edge to the return to IDLE SHALL be WIDTH+3 clk cycles.

Reset
REQ-021 clr_n=0 SHALL immediately force state=IDLE, sdo=1, busy=0, done=0, shift register=0, counter=0, regardless of clk.
REQ-022 Reset asserted mid-frame SHALL abort the frame, with no done pulse; after release the block SHALL accept a new load.

Structure
REQ-023 State encodings (3-bit localparams) SHALL live in a shared header piso_tx_defs.vh, included by both the RTL and the bench.
REQ-024 The bit counter SHALL be a sub-module bit_cnt with ports clk, clr_n, clr_sync, en and cnt, and a WIDTH parameter.

Verification (clk period 20 ns; stimulus changes on falling edges)
REQ-025 Reset: clr_n=0 mid-cycle -> sdo=1, busy=0, done=0 before the next rising edge.
REQ-026 ce=1 held, d=4'b1010, load for one cycle -> sdo per cycle 0,0,1,0,1,0,1; busy high for 7 cycles; done high for 1 cycle.
REQ-027 ce pulsed every 4th clk, d=4'b0111 -> each bit held 4 clks; sdo sequence 0,1,1,1,0,1 (parity 1),1.
REQ-028 load=1 with d=4'b1111 issued during the DATA bits of a d=4'b0001 frame -> frame unchanged (0,1,0,0,0,1,1) and no second frame starts.
REQ-029 clr_n pulsed low during PARITY -> sdo=1 immediately, no done pulse; the next load with d=4'b0101 produces 0,1,0,1,0,0,1.
REQ-030 load held high continuously with ce=1 -> back-to-back frames separated by exactly one IDLE cycle with sdo=1.
